// File: rtl/accum_pkg.sv
// ============================================================================
//  Module      : accum_pkg
//  Description : Shared definitions for the partial-sum accumulator slice:
//                default widths, FSM state encoding and a small helper that
//                maps a configured group length of zero onto one beat.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package accum_pkg;

    // Default widths used as parameter defaults by the accumulator top.
    localparam int C_DEFAULT_INPUT_WIDTH  = 32;
    localparam int C_DEFAULT_ACCUM_WIDTH  = 48;
    localparam int C_DEFAULT_OUTPUT_WIDTH = 16;
    localparam int C_DEFAULT_COUNT_WIDTH  = 16;
    localparam int C_SHIFT_WIDTH          = 5;

    // Group FSM: IDLE means no beat of the current group has been taken yet.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } accum_state_t;

    // A group length of zero is meaningless, so it behaves as one beat.
    function automatic logic [C_DEFAULT_COUNT_WIDTH-1:0] effective_count(
        input logic [C_DEFAULT_COUNT_WIDTH-1:0] num
    );
        effective_count = (num == '0) ? C_DEFAULT_COUNT_WIDTH'(1) : num;
    endfunction

endpackage

`default_nettype wire

// File: rtl/output_saturate.sv
// ============================================================================
//  Module      : output_saturate
//  Description : Combinational arithmetic right shift (floor) of a signed
//                accumulator value followed by saturation to the signed
//                output range.
//  Ports       : sum    - signed accumulator value (C_ACCUM_WIDTH)
//                shift  - arithmetic right-shift amount (0..31)
//                result - shifted, saturated value (C_OUTPUT_WIDTH)
//                sat    - high when result was clipped
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module output_saturate #(
    parameter int C_ACCUM_WIDTH  = 48,
    parameter int C_OUTPUT_WIDTH = 16
) (
    input  logic [C_ACCUM_WIDTH-1:0]  sum,
    input  logic [4:0]                shift,
    output logic [C_OUTPUT_WIDTH-1:0] result,
    output logic                      sat
);

    // Bits from the output sign bit upward must all agree for the value to fit.
    localparam int c_upper_width = C_ACCUM_WIDTH - C_OUTPUT_WIDTH + 1;

    logic signed [C_ACCUM_WIDTH-1:0] w_shifted;
    logic        [c_upper_width-1:0] w_upper;
    logic                            w_in_range;

    // >>> on a signed operand rounds toward minus infinity.
    assign w_shifted  = $signed(sum) >>> shift;
    assign w_upper    = w_shifted[C_ACCUM_WIDTH-1:C_OUTPUT_WIDTH-1];
    assign w_in_range = (&w_upper) | ~(|w_upper);

    always_comb begin
        result = w_shifted[C_OUTPUT_WIDTH-1:0];
        sat    = 1'b0;
        if (!w_in_range) begin
            sat    = 1'b1;
            result = w_shifted[C_ACCUM_WIDTH-1] ? {1'b1, {(C_OUTPUT_WIDTH-1){1'b0}}}
                                                : {1'b0, {(C_OUTPUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

`default_nettype wire

// File: rtl/partial_sum_accumulator.sv
// ============================================================================
//  Module      : partial_sum_accumulator
//  Description : Accumulates groups of signed partial sums, then emits the
//                shifted and saturated group total through a single output
//                register with valid/ready handshaking on both sides.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                cfg_num_partials   - beats per group (0 behaves as 1)
//                cfg_shift          - arithmetic right shift of group sum
//                datain_valid/ready - input handshake
//                datain             - signed partial sum
//                dataout_valid/ready- output handshake
//                dataout            - signed saturated group result
//                dataout_sat        - result was clipped
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module partial_sum_accumulator
    import accum_pkg::*;
#(
    parameter int C_INPUT_WIDTH  = C_DEFAULT_INPUT_WIDTH,
    parameter int C_ACCUM_WIDTH  = C_DEFAULT_ACCUM_WIDTH,
    parameter int C_OUTPUT_WIDTH = C_DEFAULT_OUTPUT_WIDTH,
    parameter int C_COUNT_WIDTH  = C_DEFAULT_COUNT_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [C_COUNT_WIDTH-1:0]  cfg_num_partials,
    input  logic [4:0]                cfg_shift,
    input  logic                      datain_valid,
    output logic                      datain_ready,
    input  logic [C_INPUT_WIDTH-1:0]  datain,
    input  logic                      dataout_ready,
    output logic                      dataout_valid,
    output logic [C_OUTPUT_WIDTH-1:0] dataout,
    output logic                      dataout_sat
);

    localparam logic [C_COUNT_WIDTH-1:0] c_count_one = C_COUNT_WIDTH'(1);

    accum_state_t              r_state;
    logic [C_ACCUM_WIDTH-1:0]  r_acc;
    logic [C_COUNT_WIDTH-1:0]  r_count;
    logic [C_COUNT_WIDTH-1:0]  r_num;
    logic [4:0]                r_shift;
    logic                      r_dataout_valid;
    logic [C_OUTPUT_WIDTH-1:0] r_dataout;
    logic                      r_dataout_sat;

    logic                      w_accept;
    logic                      w_idle;
    logic [C_COUNT_WIDTH-1:0]  w_n_eff;
    logic [4:0]                w_shift_eff;
    logic [C_ACCUM_WIDTH-1:0]  w_data_ext;
    logic [C_ACCUM_WIDTH-1:0]  w_sum;
    logic [C_COUNT_WIDTH-1:0]  w_count_next;
    logic                      w_last;
    logic [C_OUTPUT_WIDTH-1:0] w_sat_result;
    logic                      w_sat_flag;

    // One output register: we can take a beat whenever that register is empty
    // or is being emptied this cycle.
    assign datain_ready = ~r_dataout_valid | dataout_ready;
    assign w_accept     = datain_valid & datain_ready;
    assign w_idle       = (r_state == ST_IDLE);

    // On the first beat of a group the live config applies; afterwards the
    // latched copy does, so mid-group config edits have no effect.
    assign w_n_eff     = w_idle ? ((cfg_num_partials == '0) ? c_count_one : cfg_num_partials)
                                : r_num;
    assign w_shift_eff = w_idle ? cfg_shift : r_shift;

    assign w_data_ext   = {{(C_ACCUM_WIDTH-C_INPUT_WIDTH){datain[C_INPUT_WIDTH-1]}}, datain};
    // r_acc and r_count are always zero in IDLE, so no special first-beat path.
    assign w_sum        = r_acc + w_data_ext;
    assign w_count_next = r_count + c_count_one;
    assign w_last       = (w_count_next == w_n_eff);

    output_saturate #(
        .C_ACCUM_WIDTH  (C_ACCUM_WIDTH),
        .C_OUTPUT_WIDTH (C_OUTPUT_WIDTH)
    ) u_output_saturate (
        .sum    (w_sum),
        .shift  (w_shift_eff),
        .result (w_sat_result),
        .sat    (w_sat_flag)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_acc           <= '0;
            r_count         <= '0;
            r_num           <= c_count_one;
            r_shift         <= '0;
            r_dataout_valid <= 1'b0;
            r_dataout       <= '0;
            r_dataout_sat   <= 1'b0;
        end else begin
            // A dequeue empties the register unless a group completes below.
            if (dataout_ready) begin
                r_dataout_valid <= 1'b0;
            end
            if (w_accept) begin
                if (w_idle) begin
                    r_num   <= w_n_eff;
                    r_shift <= cfg_shift;
                end
                if (w_last) begin
                    r_dataout       <= w_sat_result;
                    r_dataout_sat   <= w_sat_flag;
                    r_dataout_valid <= 1'b1;
                    r_acc           <= '0;
                    r_count         <= '0;
                    r_state         <= ST_IDLE;
                end else begin
                    r_acc   <= w_sum;
                    r_count <= w_count_next;
                    r_state <= ST_ACCUM;
                end
            end
        end
    end

    assign dataout_valid = r_dataout_valid;
    assign dataout       = r_dataout;
    assign dataout_sat   = r_dataout_sat;

endmodule

`default_nettype wire

// File: tb/tb_partial_sum_accumulator.sv
// ============================================================================
//  Module      : tb_partial_sum_accumulator
//  Description : Self-checking bench for partial_sum_accumulator: a table of
//                single-group vectors plus hand-written backpressure, reset
//                and config-latching sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_partial_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_num_partials;
    logic [4:0]  cfg_shift;
    logic        datain_valid;
    logic        datain_ready;
    logic [31:0] datain;
    logic        dataout_ready;
    logic        dataout_valid;
    logic [15:0] dataout;
    logic        dataout_sat;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    partial_sum_accumulator #(
        .C_INPUT_WIDTH  (32),
        .C_ACCUM_WIDTH  (48),
        .C_OUTPUT_WIDTH (16),
        .C_COUNT_WIDTH  (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .cfg_num_partials (cfg_num_partials),
        .cfg_shift        (cfg_shift),
        .datain_valid     (datain_valid),
        .datain_ready     (datain_ready),
        .datain           (datain),
        .dataout_ready    (dataout_ready),
        .dataout_valid    (dataout_valid),
        .dataout          (dataout),
        .dataout_sat      (dataout_sat)
    );

    typedef struct {
        string           name;
        logic [15:0]     n;
        logic [4:0]      shift;
        logic [3:0][31:0] d;
        logic [15:0]     exp_out;
        logic            exp_sat;
    } vec_t;

    vec_t vecs[11];

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        cfg_num_partials = 16'd1;
        cfg_shift        = 5'd0;
        datain_valid     = 1'b0;
        datain           = '0;
        dataout_ready    = 1'b1;

        vecs[0]  = '{"n4_sum16",     16'd4, 5'd0,  {32'd2, 32'd7, -32'sd3, 32'd10},      16'd16,     1'b0};
        vecs[1]  = '{"n2_floor",     16'd2, 5'd2,  {32'd0, 32'd0, -32'sd2, -32'sd5},     16'hFFFE,   1'b0};
        vecs[2]  = '{"sat_pos",      16'd2, 5'd0,  {32'd0, 32'd0, 32'd10000, 32'd30000}, 16'h7FFF,   1'b1};
        vecs[3]  = '{"sat_neg",      16'd2, 5'd0,  {32'd0, 32'd0, -32'sd10000, -32'sd30000}, 16'h8000, 1'b1};
        vecs[4]  = '{"n0_as_1",      16'd0, 5'd0,  {32'd0, 32'd0, 32'd0, 32'd7},         16'd7,      1'b0};
        vecs[5]  = '{"n3_shift4",    16'd3, 5'd4,  {32'd0, -32'sd500, 32'd2000, 32'd1000}, 16'd156,  1'b0};
        vecs[6]  = '{"max_exact",    16'd1, 5'd0,  {32'd0, 32'd0, 32'd0, 32'd32767},     16'h7FFF,   1'b0};
        vecs[7]  = '{"min_exact",    16'd1, 5'd0,  {32'd0, 32'd0, 32'd0, -32'sd32768},   16'h8000,   1'b0};
        vecs[8]  = '{"max_plus1",    16'd1, 5'd0,  {32'd0, 32'd0, 32'd0, 32'd32768},     16'h7FFF,   1'b1};
        vecs[9]  = '{"wide_acc",     16'd2, 5'd16, {32'd0, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF}, 16'h7FFF, 1'b1};
        vecs[10] = '{"neg1_shift",   16'd1, 5'd1,  {32'd0, 32'd0, 32'd0, 32'hFFFFFFFF},  16'hFFFF,   1'b0};

        tick();
        rst = 1'b0;
        chk("reset_valid", {31'b0, dataout_valid}, 32'd0);
        chk("reset_dout",  {16'b0, dataout},       32'd0);
        chk("reset_sat",   {31'b0, dataout_sat},   32'd0);
        chk("reset_ready", {31'b0, datain_ready},  32'd1);

        // ---------------- table-driven single groups ----------------
        for (int v = 0; v < 11; v++) begin
            int nb;
            nb = (vecs[v].n == 16'd0) ? 1 : int'(vecs[v].n);
            cfg_num_partials = vecs[v].n;
            cfg_shift        = vecs[v].shift;
            for (int b = 0; b < nb; b++) begin
                datain_valid = 1'b1;
                datain       = vecs[v].d[b];
                tick();
                if (b < nb - 1)
                    chk({vecs[v].name, "_early"}, {31'b0, dataout_valid}, 32'd0);
            end
            datain_valid = 1'b0;
            chk({vecs[v].name, "_valid"}, {31'b0, dataout_valid}, 32'd1);
            chk({vecs[v].name, "_dout"},  {16'b0, dataout},       {16'b0, vecs[v].exp_out});
            chk({vecs[v].name, "_sat"},   {31'b0, dataout_sat},   {31'b0, vecs[v].exp_sat});
            tick();
            chk({vecs[v].name, "_drop"},  {31'b0, dataout_valid}, 32'd0);
        end

        // ---------------- backpressure with N=1 ----------------
        cfg_num_partials = 16'd1;
        cfg_shift        = 5'd0;
        dataout_ready    = 1'b0;
        datain_valid     = 1'b1;
        datain           = 32'd5;
        tick();
        datain = 32'd6;
        for (int k = 0; k < 3; k++) begin
            chk("bp_valid_hold", {31'b0, dataout_valid}, 32'd1);
            chk("bp_dout_hold",  {16'b0, dataout},       32'd5);
            chk("bp_in_ready",   {31'b0, datain_ready},  32'd0);
            tick();
        end
        dataout_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'b0, datain_ready}, 32'd1);
        chk("bp_first_result",  {16'b0, dataout},      32'd5);
        tick();
        datain_valid = 1'b0;
        chk("bp_second_valid",  {31'b0, dataout_valid}, 32'd1);
        chk("bp_second_result", {16'b0, dataout},       32'd6);
        tick();
        chk("bp_drained",       {31'b0, dataout_valid}, 32'd0);

        // ---------------- reset discards pending result and partial group ----
        dataout_ready    = 1'b0;
        datain_valid     = 1'b1;
        datain           = 32'd9;
        tick();
        datain_valid = 1'b0;
        chk("pend_valid", {31'b0, dataout_valid}, 32'd1);
        do_reset();
        chk("pend_discard", {31'b0, dataout_valid}, 32'd0);
        dataout_ready    = 1'b1;
        cfg_num_partials = 16'd4;
        for (int b = 0; b < 2; b++) begin
            datain_valid = 1'b1;
            datain       = 32'd100;
            tick();
        end
        datain_valid = 1'b0;
        do_reset();
        chk("rst_mid_valid", {31'b0, dataout_valid}, 32'd0);
        chk("rst_mid_dout",  {16'b0, dataout},       32'd0);
        chk("rst_mid_ready", {31'b0, datain_ready},  32'd1);
        for (int b = 0; b < 4; b++) begin
            datain_valid = 1'b1;
            datain       = 32'd1;
            tick();
            if (b < 3)
                chk("rst_regroup_early", {31'b0, dataout_valid}, 32'd0);
        end
        datain_valid = 1'b0;
        chk("rst_regroup_valid", {31'b0, dataout_valid}, 32'd1);
        chk("rst_regroup_dout",  {16'b0, dataout},       32'd4);
        tick();

        // ---------------- config latched at group start ----------------
        cfg_num_partials = 16'd3;
        cfg_shift        = 5'd0;
        datain_valid     = 1'b1;
        datain           = 32'd10;
        tick();
        cfg_num_partials = 16'd5;
        cfg_shift        = 5'd3;
        datain           = 32'd20;
        tick();
        chk("latch_early", {31'b0, dataout_valid}, 32'd0);
        datain = 32'd30;
        tick();
        datain_valid = 1'b0;
        chk("latch_close3", {31'b0, dataout_valid}, 32'd1);
        chk("latch_dout",   {16'b0, dataout},       32'd60);
        tick();

        // N=0 behaves as 1: every beat emits, back to back.
        cfg_num_partials = 16'd0;
        cfg_shift        = 5'd0;
        datain_valid     = 1'b1;
        datain           = 32'd4;
        tick();
        chk("n0_first_valid", {31'b0, dataout_valid}, 32'd1);
        chk("n0_first_dout",  {16'b0, dataout},       32'd4);
        datain = 32'hFFFFFFFC;
        tick();
        datain_valid = 1'b0;
        chk("n0_second_valid", {31'b0, dataout_valid}, 32'd1);
        chk("n0_second_dout",  {16'b0, dataout},       32'h0000FFFC);
        tick();
        chk("n0_drained", {31'b0, dataout_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
